// File: rtl/imem_program_loader.sv
// imem_program_loader - buffers (address, instruction) stream words and writes them into IMEM, holding the core in reset until loaded.
// Revision: 1.0
`default_nettype none

module imem_program_loader #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int IMEM_WORDS      = 64,
  parameter int CORE_RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              imem_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded,
  input  logic              reload
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(CORE_RST_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              last_seen;
  logic [HOLD_W-1:0] hold_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic              head_in_range;

  assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty    = (count == '0);
  // Ready uses only registered occupancy, so a same-cycle pop never opens room for a push.
  assign s_ready       = reset && !fifo_full && !last_seen && (state == IDLE || state == LOAD);
  assign push          = s_valid && s_ready;
  assign pop           = (state == LOAD) && !fifo_empty && imem_ready;
  assign head_addr     = fifo_addr[rd_ptr];
  assign head_in_range = (head_addr < ADDR_W'(IMEM_WORDS));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= s_addr;
      fifo_data[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      last_seen     <= 1'b0;
      hold_cnt      <= '0;
      write_en      <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      core_reset    <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= '0;
    end else begin
      write_en <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (s_last) last_seen <= 1'b1;
      end

      // Out-of-range words are still consumed so the stream keeps moving.
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (head_in_range) begin
          write_en      <= 1'b1;
          write_address <= head_addr;
          write_data    <= fifo_data[rd_ptr];
          if (words_loaded != 16'hFFFF) words_loaded <= words_loaded + 16'd1;
        end else begin
          error <= 1'b1;
        end
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (push) state <= LOAD;
        end
        LOAD: begin
          if (last_seen && fifo_empty) begin
            state    <= HOLD;
            hold_cnt <= HOLD_W'(CORE_RST_CYCLES);
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
          if (hold_cnt == HOLD_W'(1)) begin
            state      <= RUN;
            core_reset <= 1'b0;
            done       <= 1'b1;
          end
        end
        RUN: begin
          if (reload) begin
            state        <= IDLE;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            last_seen    <= 1'b0;
            words_loaded <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader - directed self-checking bench with a write scoreboard for imem_program_loader.
// Revision: 1.0
`default_nettype none

module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [31:0] s_data;
  logic        s_last;
  logic        imem_ready;
  logic        write_en;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic        reload;

  always #5 clk = ~clk;

  imem_program_loader #(
    .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .IMEM_WORDS(64), .CORE_RST_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_data(s_data), .s_last(s_last), .imem_ready(imem_ready),
    .write_en(write_en), .write_address(write_address), .write_data(write_data),
    .core_reset(core_reset), .done(done), .error(error),
    .words_loaded(words_loaded), .reload(reload)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  first_wr = -1;
  int  last_wr  = -1;
  int  n_wr     = 0;
  int  acc_cyc  = 0;
  int  done_cyc = 0;
  int  n0       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every IMEM write must match the oldest in-range word the bench handed over.
  always @(negedge clk) begin
    if (write_en) begin
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", write_address, mon_e.a);
        check("wr_data", write_data, mon_e.d);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic l);
    int t = 0;
    s_valid = 1'b1; s_addr = a; s_data = d; s_last = l;
    #1;
    while (!s_ready && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (!s_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      @(negedge clk);
    end else begin
      @(posedge clk);
      if (a < 32'd64) exp_q.push_back({a, d});
      @(negedge clk);
      acc_cyc = cyc;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk); t++;
    end
    done_cyc = cyc;
    check("done_reached", done, 1);
    check("core_reset_run", core_reset, 0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_core_reset", core_reset, 1);
    check("reload_done", done, 0);
    check("reload_s_ready", s_ready, 1);
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_addr = '0; s_data = '0; s_last = 1'b0;
    imem_ready = 1'b1; reload = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_write_en", write_en, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_wr_addr_data", {write_address, write_data}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_core_reset", core_reset, 1);

    // Back-to-back three-word program
    first_wr = -1; n_wr = 0;
    send(32'd10, 32'h00500213, 1'b0);
    n0 = acc_cyc;
    send(32'd11, 32'h00800293, 1'b0);
    send(32'd15, 32'h004283B3, 1'b1);
    wait_done();
    check("t2_first_write_cyc", first_wr, n0 + 1);
    check("t2_last_write_cyc", last_wr, n0 + 3);
    check("t2_n_writes", n_wr, 3);
    check("t2_words_loaded", words_loaded, 3);
    check("t2_release_delay", done_cyc - last_wr, 3);
    check("t2_queue_empty", exp_q.size(), 0);
    do_reload();

    // Backpressure: FIFO fills at 4 while IMEM stalls
    imem_ready = 1'b0; n_wr = 0;
    for (int i = 0; i < 4; i++) send(32'd20 + i, 32'h00100093 + i, 1'b0);
    s_valid = 1'b1; s_addr = 32'd24; s_data = 32'h00100097; s_last = 1'b1;
    #1;
    check("t3_full_s_ready", s_ready, 0);
    @(negedge clk); #1;
    check("t3_full_s_ready_hold", s_ready, 0);
    check("t3_no_write_stalled", n_wr, 0);
    imem_ready = 1'b1;
    send(32'd24, 32'h00100097, 1'b1);
    wait_done();
    check("t3_n_writes", n_wr, 5);
    check("t3_words_loaded", words_loaded, 5);
    check("t3_queue_empty", exp_q.size(), 0);
    do_reload();

    // Out-of-range address is dropped and flagged
    n_wr = 0;
    send(32'd64, 32'h00200413, 1'b0);
    repeat (2) @(negedge clk);
    check("t4_error", error, 1);
    check("t4_no_write", n_wr, 0);
    check("t4_words_unchanged", words_loaded, 0);
    send(32'd7, 32'h00100093, 1'b1);
    wait_done();
    check("t4_words_loaded", words_loaded, 1);
    check("t4_error_held", error, 1);
    do_reload();
    check("t4_error_sticky", error, 1);

    // Reset while words are buffered
    imem_ready = 1'b0;
    send(32'd30, 32'h00000013, 1'b0);
    send(32'd31, 32'h00000033, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t5_core_reset", core_reset, 1);
    check("t5_s_ready_low", s_ready, 0);
    check("t5_error_cleared", error, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1; imem_ready = 1'b1; n_wr = 0;
    repeat (5) @(negedge clk);
    check("t5_no_write", n_wr, 0);
    check("t5_idle_s_ready", s_ready, 1);
    check("t5_idle_core_reset", core_reset, 1);
    check("t5_idle_done", done, 0);

    // Run, reload, second program
    send(32'd40, 32'h00000013, 1'b1);
    wait_done();
    check("t6_words_loaded_a", words_loaded, 1);
    do_reload();
    check("t6_words_cleared", words_loaded, 0);
    send(32'd41, 32'h00100113, 1'b1);
    wait_done();
    check("t6_words_loaded_b", words_loaded, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
